// File: rtl/upsample_unit.sv
// Nearest-neighbour upsampler: stores one source row, then replays each pixel
// scale_x times per line and each line scale_y times before taking the next row.
`timescale 1ns/1ps
`ifndef QW
`define QW 8
`endif
`ifndef XW
`define XW 4
`endif

module upsample_unit #(
  parameter int ifsize_x = 8,
  parameter int ifsize_y = 8,
  parameter int scale_x  = 2,
  parameter int scale_y  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [`XW*`QW-1:0]     data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [`XW*`QW-1:0]     data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   last_o
);

  localparam int PW   = `XW * `QW;
  localparam int IX_W = (ifsize_x > 1) ? $clog2(ifsize_x) : 1;
  localparam int IY_W = (ifsize_y > 1) ? $clog2(ifsize_y) : 1;
  localparam int SX_W = (scale_x  > 1) ? $clog2(scale_x)  : 1;
  localparam int SY_W = (scale_y  > 1) ? $clog2(scale_y)  : 1;

  localparam logic [IX_W-1:0] IX_MAX = IX_W'(ifsize_x - 1);
  localparam logic [IY_W-1:0] IY_MAX = IY_W'(ifsize_y - 1);
  localparam logic [SX_W-1:0] SX_MAX = SX_W'(scale_x - 1);
  localparam logic [SY_W-1:0] SY_MAX = SY_W'(scale_y - 1);

  typedef enum logic {FILL, EMIT} state_t;

  state_t          r_state;
  state_t          w_nextState;

  logic [PW-1:0]   r_buf [ifsize_x];
  logic [IX_W-1:0] r_inX;
  logic [IX_W-1:0] r_outX;
  logic [SX_W-1:0] r_repX;
  logic [SY_W-1:0] r_repY;
  logic [IY_W-1:0] r_inY;

  logic            w_inAcc;
  logic            w_outAcc;
  logic            w_inXMax;
  logic            w_outXMax;
  logic            w_repXMax;
  logic            w_repYMax;
  logic            w_inYMax;
  logic            w_rowDone;

  assign w_inAcc   = valid_i & ready_o;
  assign w_outAcc  = valid_o & ready_i;
  assign w_inXMax  = (r_inX  == IX_MAX);
  assign w_outXMax = (r_outX == IX_MAX);
  assign w_repXMax = (r_repX == SX_MAX);
  assign w_repYMax = (r_repY == SY_MAX);
  assign w_inYMax  = (r_inY  == IY_MAX);
  assign w_rowDone = w_repXMax & w_outXMax & w_repYMax;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      FILL:    if (w_inAcc && w_inXMax) w_nextState = EMIT;
      EMIT:    if (w_outAcc && w_rowDone) w_nextState = FILL;
      default: w_nextState = FILL;
    endcase
  end

  // Both handshakes are masked during reset so nothing leaks out of an aborted frame.
  always_comb begin
    ready_o = 1'b0;
    valid_o = 1'b0;
    data_o  = '0;
    last_o  = 1'b0;
    if (!rst) begin
      case (r_state)
        FILL: ready_o = 1'b1;
        EMIT: begin
          valid_o = 1'b1;
          data_o  = r_buf[r_outX];
          last_o  = w_rowDone & w_inYMax;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ifsize_x; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_inAcc) begin
      r_buf[r_inX] <= data_i;
    end
  end

  // Counters cascade like an odometer: rep_x, then source column, then line repeat, then source row.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inX  <= '0;
      r_outX <= '0;
      r_repX <= '0;
      r_repY <= '0;
      r_inY  <= '0;
    end else begin
      if (w_inAcc) begin
        r_inX <= w_inXMax ? '0 : r_inX + IX_W'(1);
      end
      if (w_outAcc) begin
        r_repX <= w_repXMax ? '0 : r_repX + SX_W'(1);
        if (w_repXMax) begin
          r_outX <= w_outXMax ? '0 : r_outX + IX_W'(1);
          if (w_outXMax) begin
            r_repY <= w_repYMax ? '0 : r_repY + SY_W'(1);
            if (w_repYMax) begin
              r_inY <= w_inYMax ? '0 : r_inY + IY_W'(1);
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_upsample_unit.sv
// Scoreboard bench for upsample_unit: a 4x2 frame at 2x2 scale (dut A) and a
// 3x3 frame at 1x1 scale (dut B), with directed hand-computed pixel values.
`timescale 1ns/1ps
`ifndef QW
`define QW 8
`endif
`ifndef XW
`define XW 4
`endif

module tb_upsample_unit;

  localparam int QW = `QW;
  localparam int XW = `XW;
  localparam int PW = QW * XW;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] dataA, dataOA, dataB, dataOB;
  logic          validA, readyOA, validOA, readyA, lastOA;
  logic          validB, readyOB, validOB, readyB, lastOB;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [PW:0]   qA[$];
  logic [PW:0]   qB[$];
  int            beatsA = 0;
  int            beatsB = 0;
  int            firstAccA = -1;
  int            lastCycA = 0;
  bit            bpMode = 1'b0;
  bit            stallA = 1'b0;
  logic [PW:0]   heldA;

  always #5 clk = ~clk;

  upsample_unit #(.ifsize_x(4), .ifsize_y(2), .scale_x(2), .scale_y(2)) dutA (
    .clk(clk), .rst(rst), .data_i(dataA), .valid_i(validA), .ready_o(readyOA),
    .data_o(dataOA), .valid_o(validOA), .ready_i(readyA), .last_o(lastOA)
  );

  upsample_unit #(.ifsize_x(3), .ifsize_y(3), .scale_x(1), .scale_y(1)) dutB (
    .clk(clk), .rst(rst), .data_i(dataB), .valid_i(validB), .ready_o(readyOB),
    .data_o(dataOB), .valid_o(validOB), .ready_i(readyB), .last_o(lastOB)
  );

  // Lane k carries base + stride*k, truncated to one word.
  function automatic logic [PW-1:0] pix(input int base, input int stride);
    logic [PW-1:0] v;
    v = '0;
    for (int k = 0; k < XW; k++) begin
      v[k*QW +: QW] = QW'(base + stride * k);
    end
    return v;
  endfunction

  function automatic logic [PW-1:0] pixA(input int r, input int c);
    return pix(16 * r + c, 1);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out, got no handshake, expected one (cycle %0d)", name, cyc);
  endtask

  // Drives one pixel into dut A (selB=0) or dut B (selB=1) after 'gap' idle cycles.
  task automatic applyStimulus(input bit selB, input logic [PW-1:0] d, input int gap);
    bit ok;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    if (selB) begin dataB = d; validB = 1'b1; end
    else      begin dataA = d; validA = 1'b1; end
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (selB ? readyOB : readyOA) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeoutFail("input_accept");
    @(posedge clk); #1;
    if (selB) begin validB = 1'b0; dataB = '1; end
    else      begin validA = 1'b0; dataA = '1; end
  endtask

  task automatic drainQueue(input bit selB);
    for (int t = 0; t < 1000; t++) begin
      if ((selB ? qB.size() : qA.size()) == 0) break;
      @(negedge clk);
    end
    if ((selB ? qB.size() : qA.size()) != 0) begin
      timeoutFail("output_drain");
      if (selB) qB.delete(); else qA.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic pushFrameA();
    for (int r = 0; r < 2; r++)
      for (int ry = 0; ry < 2; ry++)
        for (int c = 0; c < 4; c++)
          for (int rx = 0; rx < 2; rx++)
            qA.push_back({(r == 1 && ry == 1 && c == 3 && rx == 1), pixA(r, c)});
  endtask

  task automatic runFrameA(input int gap);
    pushFrameA();
    beatsA = 0;
    firstAccA = -1;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++)
        applyStimulus(1'b0, pixA(r, c), gap);
    drainQueue(1'b0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk); #1;
    readyA = bpMode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor for dut A: scoreboard pops, stall-hold and EMIT-side ready checks.
  initial forever begin
    logic [PW:0] exp;
    @(negedge clk);
    if (validOA) checkOutput("readyA_low_in_emit", 64'(readyOA), 64'd0);
    if (stallA && validOA) checkOutput("hold_while_stalled", 64'({lastOA, dataOA}), 64'(heldA));
    if (validOA && readyA) begin
      if (qA.size() == 0) begin
        checkOutput("unexpected_beatA", 64'({lastOA, dataOA}), 64'd0);
      end else begin
        exp = qA.pop_front();
        checkOutput("beatA", 64'({lastOA, dataOA}), 64'(exp));
      end
      beatsA++;
      if (lastOA) lastCycA = cyc + 1;
    end
    if (validOA && !readyA) begin
      stallA = 1'b1;
      heldA = {lastOA, dataOA};
    end else begin
      stallA = 1'b0;
    end
    if (validA && readyOA && firstAccA < 0) firstAccA = cyc + 1;
  end

  initial forever begin
    logic [PW:0] exp;
    @(negedge clk);
    if (validOB && readyB) begin
      if (qB.size() == 0) begin
        checkOutput("unexpected_beatB", 64'({lastOB, dataOB}), 64'd0);
      end else begin
        exp = qB.pop_front();
        checkOutput("beatB", 64'({lastOB, dataOB}), 64'(exp));
      end
      beatsB++;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    rst = 1'b1;
    validA = 1'b1; dataA = {XW{8'hAA}};
    validB = 1'b0; dataB = '0;
    readyB = 1'b1;

    // Reset holds both handshakes and the data bus low even with valid input.
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("rst_ready", 64'(readyOA), 64'd0);
      checkOutput("rst_valid", 64'(validOA), 64'd0);
      checkOutput("rst_data", 64'(dataOA), 64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    validA = 1'b0; dataA = '1;
    @(negedge clk);
    checkOutput("ready_after_rst", 64'(readyOA), 64'd1);
    checkOutput("valid_after_rst", 64'(validOA), 64'd0);
    @(posedge clk); #1;

    runFrameA(0);
    checkOutput("beats_basic", 64'(beatsA), 64'd32);
    checkOutput("frame_cycles", 64'(lastCycA - firstAccA), 64'd39);

    bpMode = 1'b1;
    runFrameA(0);
    checkOutput("beats_backpressure", 64'(beatsA), 64'd32);
    bpMode = 1'b0;
    @(posedge clk); #1;

    runFrameA(2);
    checkOutput("beats_gaps", 64'(beatsA), 64'd32);

    for (int p = 0; p < 9; p++) qB.push_back({(p == 8), pix(p, 16)});
    beatsB = 0;
    for (int p = 0; p < 9; p++) applyStimulus(1'b1, pix(p, 16), 0);
    drainQueue(1'b1);
    checkOutput("beats_1x1", 64'(beatsB), 64'd9);

    // Abort a frame after five output beats, then expect a clean restart.
    pushFrameA();
    beatsA = 0;
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, pixA(0, c), 0);
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(posedge clk); #1;
      if (beatsA >= 5) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeoutFail("five_beats");
    rst = 1'b1;
    qA.delete();
    @(negedge clk);
    checkOutput("valid_in_midrst", 64'(validOA), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("valid_after_midrst", 64'(validOA), 64'd0);
    checkOutput("ready_after_midrst", 64'(readyOA), 64'd1);
    @(posedge clk); #1;

    runFrameA(0);
    checkOutput("beats_after_midrst", 64'(beatsA), 64'd32);
    checkOutput("frame_cycles_after_midrst", 64'(lastCycA - firstAccA), 64'd39);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
